// File: rtl/ex_mem_skid_reg.sv
// Elastic EX->MEM pipeline register with a two-entry skid buffer.
// in_ready comes straight from a flop, so a MEM stall never feeds combinationally back into EX.
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W         = 76,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter bit          ZERO_BUBBLE    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              acc, rel;

  assign acc = in_valid && !skid_valid_q && !flush;
  assign rel = main_valid_q && out_ready;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (!main_valid_q) begin
      if (acc) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end
    end else if (rel) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so nothing new can arrive this cycle.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the payload is cleared on reset
  // as well so out_data is deterministic when ZERO_BUBBLE is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign in_ready  = !skid_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign out_data  = (ZERO_BUBBLE && !main_valid_q) ? '0 : main_data_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed and randomised checks for ex_mem_skid_reg, with a second instance that keeps payload
// on flush and shows raw main-entry contents.
module tb_ex_mem_skid_reg;
  localparam int DW = 76;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [1:0]    occ_a, occ_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .ZERO_BUBBLE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .occupancy(occ_a)
  );

  ex_mem_skid_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .ZERO_BUBBLE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .occupancy(occ_b)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic expect_a(input string tag, input logic ov, input logic ir,
                          input logic [1:0] oc, input logic [DW-1:0] od);
    check({tag, ".out_valid"}, 96'(out_valid_a), 96'(ov));
    check({tag, ".in_ready"},  96'(in_ready_a),  96'(ir));
    check({tag, ".occupancy"}, 96'(occ_a),       96'(oc));
    check({tag, ".out_data"},  96'(out_data_a),  96'(od));
  endtask

  task automatic fill_5_6();
    drive(1'b1, DW'(5), 1'b1, 1'b0); tick();
    drive(1'b1, DW'(6), 1'b0, 1'b0); tick();
  endtask

  logic [DW-1:0] sb[$];
  logic          acc, pop;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    expect_a("reset", 1'b0, 1'b1, 2'd0, '0);
    check("reset.b_out_data", 96'(out_data_b), 96'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0); tick();
      expect_a($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, DW'(i));
    end
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    expect_a("stream_drain", 1'b0, 1'b1, 2'd0, '0);

    // Stall: 5 in main, 6 goes to skid, 7 held back.
    fill_5_6();
    expect_a("stall_full", 1'b1, 1'b0, 2'd2, DW'(5));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(7), 1'b0, 1'b0); tick();
      expect_a($sformatf("stall_hold%0d", i), 1'b1, 1'b0, 2'd2, DW'(5));
    end
    drive(1'b1, DW'(7), 1'b1, 1'b0); tick();
    expect_a("stall_rel6", 1'b1, 1'b1, 2'd1, DW'(6));
    tick();
    expect_a("stall_rel7", 1'b1, 1'b1, 2'd1, DW'(7));
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    expect_a("stall_drain", 1'b0, 1'b1, 2'd0, '0);

    // Flush while full; 7 must never appear.
    fill_5_6();
    drive(1'b1, DW'(7), 1'b0, 1'b1); tick();
    expect_a("flush_full", 1'b0, 1'b1, 2'd0, '0);
    check("flush_full.b_occ", 96'(occ_b), 96'd0);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    expect_a("flush_full_after", 1'b0, 1'b1, 2'd0, '0);

    // Flush with MEM consuming 9 in the same cycle.
    drive(1'b1, DW'(9), 1'b1, 1'b0); tick();
    expect_a("flush_rel_pre", 1'b1, 1'b1, 2'd1, DW'(9));
    drive(1'b1, DW'(10), 1'b1, 1'b1); tick();
    expect_a("flush_rel", 1'b0, 1'b1, 2'd0, '0);
    check("flush_rel.b_out_valid", 96'(out_valid_b), 96'd0);
    check("flush_rel.b_out_data",  96'(out_data_b),  96'd9);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    check("flush_rel.b_hold", 96'(out_data_b), 96'd9);

    // Reset mid-stall with both entries full.
    fill_5_6();
    drive(1'b1, DW'(7), 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_a("rst_stall", 1'b0, 1'b1, 2'd0, '0);
    check("rst_stall.b_out_data", 96'(out_data_b), 96'd0);
    check("rst_stall.b_occ",      96'(occ_b),      96'd0);
    drive(1'b1, DW'('h11), 1'b0, 1'b0); tick();
    expect_a("rst_first", 1'b1, 1'b1, 2'd1, DW'('h11));
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    expect_a("rst_drain", 1'b0, 1'b1, 2'd0, '0);

    // Random traffic against a FIFO scoreboard.
    sb.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      acc = in_valid && (sb.size() < 2) && !flush;
      in_data = acc ? DW'({$urandom, $urandom, $urandom}) : 'x;
      check("rnd.occupancy", 96'(occ_a), 96'(sb.size()));
      check("rnd.in_ready",  96'(in_ready_a), 96'(sb.size() < 2));
      check("rnd.out_valid", 96'(out_valid_a), 96'(sb.size() != 0));
      check("rnd.b_out_valid", 96'(out_valid_b), 96'(sb.size() != 0));
      pop = (sb.size() != 0) && out_ready;
      if (sb.size() != 0) begin
        check("rnd.out_data",   96'(out_data_a), 96'(sb[0]));
        check("rnd.b_out_data", 96'(out_data_b), 96'(sb[0]));
      end else begin
        check("rnd.bubble", 96'(out_data_a), 96'd0);
      end
      if (pop) void'(sb.pop_front());
      if (flush) sb.delete();
      if (acc) sb.push_back(in_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
